// File: rtl/sad_pkg.sv
// Shared types and default constants for the parallel sum-of-absolute-differences block.
package sad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DONE
  } sad_state_e;

  localparam int unsigned SAD_DATA_W    = 8;
  localparam int unsigned SAD_LANES     = 4;
  localparam int unsigned SAD_BLOCK_LEN = 16;
  localparam int unsigned SAD_ACC_W     = 32;

  // Width of one beat's lane sum: an abs-diff needs DATA_W+1 bits, plus growth over LANES.
  function automatic int unsigned sad_sum_w(input int unsigned data_w, input int unsigned lanes);
    return data_w + $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/sad_par_if.sv
// Sample-beat bus: valid strobe plus packed operand A/B lanes (lane i at [i*DATA_W +: DATA_W]).
interface sad_par_if
  import sad_pkg::*;
#(
  parameter int unsigned DATA_W = SAD_DATA_W,
  parameter int unsigned LANES  = SAD_LANES
);

  logic                    vld;
  logic [LANES*DATA_W-1:0] dta;
  logic [LANES*DATA_W-1:0] dtb;

  modport master (output vld, dta, dtb);
  modport slave  (input  vld, dta, dtb);

endinterface

// File: rtl/sad_absdiff.sv
// Combinational per-beat SAD: sum over lanes of |a_i - b_i|, zero when the beat is not valid.
module sad_absdiff
  import sad_pkg::*;
#(
  parameter int unsigned DATA_W = SAD_DATA_W,
  parameter int unsigned LANES  = SAD_LANES,
  localparam int unsigned SUM_W = sad_sum_w(DATA_W, LANES)
) (
  sad_par_if.slave         bus,
  output logic [SUM_W-1:0] sum_o
);

  logic [DATA_W:0]  a_ext;
  logic [DATA_W:0]  b_ext;
  logic [DATA_W:0]  diff;
  logic [SUM_W-1:0] sum;

  // Operands are zero-extended by one bit so the difference never wraps.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    diff  = '0;
    sum   = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_ext = {1'b0, bus.dta[i*DATA_W +: DATA_W]};
      b_ext = {1'b0, bus.dtb[i*DATA_W +: DATA_W]};
      diff  = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
      sum   = sum + SUM_W'(diff);
    end
  end

  always_comb begin
    sum_o = bus.vld ? sum : '0;
  end

endmodule

// File: rtl/sad_par.sv
// Block SAD engine: accumulates BLOCK_LEN valid beats, then reports the sum with a done pulse.
// Define SAD_SAT_EN to saturate the accumulator instead of wrapping modulo 2**ACC_W.
module sad_par
  import sad_pkg::*;
#(
  parameter int unsigned DATA_W    = SAD_DATA_W,
  parameter int unsigned LANES     = SAD_LANES,
  parameter int unsigned BLOCK_LEN = SAD_BLOCK_LEN,
  parameter int unsigned ACC_W     = SAD_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enb,
  input  logic                    din_vld,
  input  logic [LANES*DATA_W-1:0] dta_in,
  input  logic [LANES*DATA_W-1:0] dtb_in,
  output logic [ACC_W-1:0]        dt_o,
  output logic                    done_o,
  output logic                    busy_o
);

  localparam int unsigned SUM_W = sad_sum_w(DATA_W, LANES);
  localparam int unsigned CNT_W = $clog2(BLOCK_LEN + 1);

  sad_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] dt_q, dt_d;
  logic [SUM_W-1:0] beat_sum;
  logic [ACC_W-1:0] acc_next;

  sad_par_if #(.DATA_W(DATA_W), .LANES(LANES)) beat_if ();

  assign beat_if.vld = din_vld;
  assign beat_if.dta = dta_in;
  assign beat_if.dtb = dtb_in;

  sad_absdiff #(.DATA_W(DATA_W), .LANES(LANES)) u_absdiff (
    .bus   (beat_if.slave),
    .sum_o (beat_sum)
  );

`ifdef SAD_SAT_EN
  logic [ACC_W:0] acc_sum;

  // Carry out of the accumulator pins it at all-ones; further adds keep it there.
  always_comb begin
    acc_sum  = {1'b0, acc_q} + (ACC_W + 1)'(beat_sum);
    acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_next = acc_q + ACC_W'(beat_sum);
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dt_d    = dt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enb) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (din_vld) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
            dt_d    = acc_next;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (enb) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dt_q    <= dt_d;
    end
  end

  assign dt_o   = dt_q;
  assign busy_o = (state_q == ST_ACCUM);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_sad_par.sv
// Scoreboard bench for sad_par: directed blocks push expected sums, a monitor checks on done_o.
module tb_sad_par;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enb;
  logic        enb12;
  logic [31:0] dt_o;
  logic        done_o;
  logic        busy_o;
  logic [11:0] dt12;
  logic        done12;
  logic        busy12;

  int n_cmp = 0;
  int n_err = 0;

  longint q_main[$];
  longint q_12[$];

  sad_par_if #(.DATA_W(8), .LANES(4)) tb_bus ();

  always #5 clk = ~clk;

  sad_par #(.DATA_W(8), .LANES(4), .BLOCK_LEN(16), .ACC_W(32)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .enb     (enb),
    .din_vld (tb_bus.vld),
    .dta_in  (tb_bus.dta),
    .dtb_in  (tb_bus.dtb),
    .dt_o    (dt_o),
    .done_o  (done_o),
    .busy_o  (busy_o)
  );

  sad_par #(.DATA_W(8), .LANES(4), .BLOCK_LEN(16), .ACC_W(12)) dut12 (
    .clk     (clk),
    .rst     (rst_n),
    .enb     (enb12),
    .din_vld (tb_bus.vld),
    .dta_in  (tb_bus.dta),
    .dtb_in  (tb_bus.dtb),
    .dt_o    (dt12),
    .done_o  (done12),
    .busy_o  (busy12)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int unsigned l0, input int unsigned l1,
                                        input int unsigned l2, input int unsigned l3);
    logic [7:0] b0, b1, b2, b3;
    b0 = l0[7:0];
    b1 = l1[7:0];
    b2 = l2[7:0];
    b3 = l3[7:0];
    return {b3, b2, b1, b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample on the falling edge, away from the stimulus sample point.
  always @(negedge clk) begin
    if (done_o) begin
      if (q_main.size() == 0) check("main_unexpected_done", 1, 0);
      else check("main_dt", dt_o, q_main.pop_front());
    end
    if (done12) begin
      if (q_12.size() == 0) check("acc12_unexpected_done", 1, 0);
      else check("acc12_dt", dt12, q_12.pop_front());
    end
  end

  task automatic run_block(input string name, input logic [31:0] a, input logic [31:0] b,
                           input bit toggle, input bit noise, input int exp_busy,
                           input longint exp_dt);
    int cyc;
    int busy_cnt;
    tb_bus.dta = a;
    tb_bus.dtb = b;
    tb_bus.vld = toggle ? 1'b0 : 1'b1;
    q_main.push_back(exp_dt);
    enb = 1'b1;
    tick();
    enb = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!done_o && cyc < 200) begin
      if (busy_o) busy_cnt++;
      if (toggle) tb_bus.vld = (cyc % 2 == 1);
      if (noise) enb = (cyc % 5 == 0);
      tick();
      cyc++;
    end
    enb = 1'b0;
    tb_bus.vld = 1'b0;
    check({name, "_busy_cycles"}, busy_cnt, exp_busy);
    tick();
    check({name, "_idle_busy"}, busy_o, 0);
    check({name, "_idle_done"}, done_o, 0);
    check({name, "_dt_hold"}, dt_o, exp_dt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    longint      e_v [3];

    rst_n      = 1'b0;
    enb        = 1'b0;
    enb12      = 1'b0;
    tb_bus.vld = 1'b0;
    tb_bus.dta = '0;
    tb_bus.dtb = '0;
    #12;
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    check("reset_dt", dt_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single active lane: |24-32| * 16 = 128.
    run_block("one_lane", pack4(24, 0, 0, 0), pack4(32, 0, 0, 0), 1'b0, 1'b0, 16, 128);
    // (10+100+255+255) * 16 = 9920.
    run_block("four_lane", pack4(10, 200, 0, 255), pack4(20, 100, 255, 0), 1'b0, 1'b0, 16, 9920);
    run_block("stall_noise", pack4(10, 200, 0, 255), pack4(20, 100, 255, 0), 1'b1, 1'b1, 32, 9920);

    // 1020 * 16 = 16320 overflows 12 bits: wraps to 4032 or saturates at 4095.
`ifdef SAD_SAT_EN
    q_12.push_back(4095);
`else
    q_12.push_back(4032);
`endif
    tb_bus.dta = pack4(255, 255, 255, 255);
    tb_bus.dtb = pack4(0, 0, 0, 0);
    tb_bus.vld = 1'b1;
    enb12 = 1'b1;
    tick();
    enb12 = 1'b0;
    cyc = 0;
    while (!done12 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("acc12_latency", cyc, 16);
    tick();
    check("acc12_idle_busy", busy12, 0);
    check("main_dt_unchanged", dt_o, 9920);
    check("main_ignores_vld_idle", busy_o, 0);

    // Reset five beats into a block.
    tb_bus.dta = pack4(10, 200, 0, 255);
    tb_bus.dtb = pack4(20, 100, 255, 0);
    tb_bus.vld = 1'b1;
    enb = 1'b1;
    tick();
    enb = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy", busy_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_dt", dt_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_idle", busy_o, 0);
    run_block("after_reset", pack4(10, 200, 0, 255), pack4(20, 100, 255, 0), 1'b0, 1'b0, 16, 9920);

    // Back-to-back blocks with enb held high; data changes while in DONE.
    a_v[0] = pack4(100, 0, 0, 0);     b_v[0] = pack4(0, 0, 0, 0);         e_v[0] = 1600;
    a_v[1] = pack4(0, 0, 0, 0);       b_v[1] = pack4(255, 255, 255, 255); e_v[1] = 16320;
    a_v[2] = pack4(50, 60, 70, 80);   b_v[2] = pack4(80, 70, 60, 50);     e_v[2] = 1280;
    tb_bus.vld = 1'b1;
    enb = 1'b1;
    tick();
    for (int j = 0; j < 3; j++) begin
      tb_bus.dta = a_v[j];
      tb_bus.dtb = b_v[j];
      q_main.push_back(e_v[j]);
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!done_o && cyc < 200);
      check($sformatf("b2b_period_%0d", j), cyc, (j == 0) ? 16 : 17);
    end
    enb = 1'b0;
    tb_bus.vld = 1'b0;
    tick();
    check("b2b_idle_busy", busy_o, 0);
    check("b2b_dt_hold", dt_o, 1280);

    tick();
    check("main_queue_empty", q_main.size(), 0);
    check("acc12_queue_empty", q_12.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sad_par.md
SAD_PAR -- requirements
Module: sad_par

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of one sample per lane.
REQ-002 SHALL have parameter LANES, default 4: number of sample pairs processed per beat.
REQ-003 SHALL have parameter BLOCK_LEN, default 16: valid beats per block (>=1).
REQ-004 SHALL have parameter ACC_W, default 32: accumulator/result width, >= DATA_W+$clog2(LANES)+1.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port enb  input  1  start-of-block request.
REQ-008 SHALL have port din_vld  input  1  sample beat valid.
REQ-009 SHALL have port dta_in  input  LANES*DATA_W  operand A lanes, lane i at bits [i*DATA_W +: DATA_W], unsigned.
REQ-010 SHALL have port dtb_in  input  LANES*DATA_W  operand B lanes, same packing, unsigned.
REQ-011 SHALL have port dt_o  output  ACC_W  last completed block SAD.
REQ-012 SHALL have port done_o  output  1  one-cycle block-complete pulse.
REQ-013 SHALL have port busy_o  output  1  block in progress.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 IDLE: enb=1 at clock edge -> ACCUM, accumulator and beat counter cleared; otherwise stay IDLE.
REQ-016 ACCUM: each edge with din_vld=1 adds sum over lanes of |a_i-b_i| to accumulator and increments counter; din_vld=0 holds both (stall, no timeout).
REQ-017 ACCUM: beat that makes count equal BLOCK_LEN -> DONE; dt_o loaded with final sum (including that beat) at same edge.
REQ-018 DONE: lasts exactly one cycle, done_o=1; enb=1 in DONE starts next block (-> ACCUM, cleared), else -> IDLE.
REQ-019 busy_o SHALL be 1 exactly in ACCUM; done_o exactly in DONE.
REQ-020 enb SHALL be ignored in ACCUM; din_vld SHALL be ignored in IDLE and DONE.
REQ-021 dt_o SHALL change only on block completion or reset; holds value otherwise.
REQ-022 Absolute difference SHALL be computed at DATA_W+1 bits, no sign wrap (|0-255|=255 for DATA_W=8).
REQ-023 Latency: dt_o valid and done_o high in the cycle after the BLOCK_LEN-th valid beat edge.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE, accumulator=0, counter=0, dt_o=0, done_o=0, busy_o=0.
REQ-025 Reset mid-block SHALL discard partial sum; dt_o reads 0 after reset.
REQ-026 Release of rst SHALL leave block in IDLE; first start needs enb sampled after release.

Configuration
REQ-027 Macro SAD_SAT_EN defined: accumulator SHALL saturate at 2**ACC_W-1 and stay there for rest of block.
REQ-028 SAD_SAT_EN undefined: accumulator SHALL wrap modulo 2**ACC_W.

Structure
REQ-029 Package sad_pkg SHALL hold the FSM state enum typedef and default parameter constants.
REQ-030 Sub-module sad_absdiff SHALL compute the combinational per-beat sum (LANES abs-diffs + adder tree), width DATA_W+$clog2(LANES)+1.
REQ-031 sad_par SHALL hold FSM, counter, accumulator, output registers.

Verification
REQ-032 LANES=1, a=24, b=32, din_vld=1 constant, enb pulse -> busy_o 16 cycles, then done_o pulse, dt_o=128.
REQ-033 LANES=4, a={10,200,0,255}, b={20,100,255,0} every beat -> dt_o=9920 after 16 beats.
REQ-034 Same as REQ-033 with din_vld toggling 1/0 -> done_o after 32 ACCUM cycles, dt_o=9920; enb pulses while busy_o=1 ignored.
REQ-035 ACC_W=12, LANES=4, all a=255, b=0 -> dt_o=4095 with SAD_SAT_EN, 4032 without.
REQ-036 rst=0 after 5 beats -> immediately busy_o=0, done_o=0, dt_o=0; new enb gives correct full result.
REQ-037 enb held high through DONE -> back-to-back blocks, done_o pulses every BLOCK_LEN+1 cycles, each result correct.
